// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: drives the PC register controls and the IF/ID, ID/EX stall/flush strobes.
// Optional stall/redirect counters are built only when STALL_CNT_EN is defined.
module fetch_sequencer #(
    parameter int unsigned RESET_HOLD_CYCLES = 4,
    parameter logic [31:0] RESET_VECTOR      = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc_cur,
    input  logic        i_imem_ready,
    input  logic        i_dmem_busy,
    input  logic [4:0]  i_id_rs1,
    input  logic [4:0]  i_id_rs2,
    input  logic        i_id_uses_rs1,
    input  logic        i_id_uses_rs2,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_mem_read,
    input  logic        i_ex_redirect,
    input  logic [31:0] i_ex_target,
    output logic        o_pc_reset,
    output logic        o_pc_stall,
    output logic [31:0] o_pc_next,
    output logic        o_if_id_stall,
    output logic        o_if_id_flush,
    output logic        o_id_ex_flush,
    output logic        o_pipe_freeze,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_count
);

    localparam int unsigned HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_stateNext;
    logic [HOLD_W-1:0] r_holdCnt;

    logic        w_loadUse;
    logic        w_rs1Hit;
    logic        w_rs2Hit;
    logic [31:0] w_redirectPc;
    logic [31:0] w_pcIncr;
    logic        w_redirectTaken;
    logic        w_unusedTargetBits;

    logic        w_pcReset;
    logic        w_pcStall;
    logic [31:0] w_pcNext;
    logic        w_ifIdStall;
    logic        w_ifIdFlush;
    logic        w_idExFlush;
    logic        w_pipeFreeze;

    // x0 is never a real dependency, so a load targeting it never stalls.
    assign w_rs1Hit  = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2Hit  = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
    assign w_loadUse = i_ex_mem_read && (i_ex_rd != 5'd0) && (w_rs1Hit || w_rs2Hit);

    assign w_redirectPc       = {i_ex_target[31:2], 2'b00};
    assign w_pcIncr           = i_pc_cur + 32'd4;
    assign w_unusedTargetBits = ^i_ex_target[1:0];

    always_comb begin
        w_stateNext     = r_state;
        w_pcReset       = 1'b0;
        w_pcStall       = 1'b0;
        w_pcNext        = i_pc_cur;
        w_ifIdStall     = 1'b0;
        w_ifIdFlush     = 1'b0;
        w_idExFlush     = 1'b0;
        w_pipeFreeze    = 1'b0;
        w_redirectTaken = 1'b0;

        case (r_state)
            ST_HOLD: begin
                w_pcReset = 1'b1;
                w_pcNext  = RESET_VECTOR;
                if (r_holdCnt <= HOLD_ONE) begin
                    w_stateNext = ST_RUN;
                end
            end

            ST_RUN: begin
                if (i_dmem_busy) begin
                    // EX is frozen, so any redirect it shows is retried once the freeze lifts.
                    w_pipeFreeze = 1'b1;
                    w_pcStall    = 1'b1;
                    w_ifIdStall  = 1'b1;
                end else if (i_ex_redirect) begin
                    w_redirectTaken = 1'b1;
                    w_pcNext        = w_redirectPc;
                    w_ifIdFlush     = 1'b1;
                    w_idExFlush     = 1'b1;
                    if (!i_imem_ready) begin
                        w_stateNext = ST_DROP;
                    end
                end else if (w_loadUse) begin
                    w_pcStall   = 1'b1;
                    w_ifIdStall = 1'b1;
                    w_idExFlush = 1'b1;
                end else if (!i_imem_ready) begin
                    w_pcStall   = 1'b1;
                    w_ifIdFlush = 1'b1;
                end else begin
                    w_pcNext = w_pcIncr;
                end
            end

            ST_DROP: begin
                // The response still in flight belongs to the old path and is thrown away.
                w_pcStall   = 1'b1;
                w_ifIdFlush = 1'b1;
                if (i_dmem_busy) begin
                    w_pipeFreeze = 1'b1;
                    w_ifIdStall  = 1'b1;
                end
                if (i_imem_ready) begin
                    w_stateNext = ST_RUN;
                end
            end

            default: begin
                w_stateNext = ST_HOLD;
                w_pcReset   = 1'b1;
                w_pcNext    = RESET_VECTOR;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_holdCnt <= HOLD_INIT;
        end else if ((r_state == ST_HOLD) && (r_holdCnt != '0)) begin
            r_holdCnt <= r_holdCnt - HOLD_ONE;
        end
    end

    assign o_pc_reset    = w_pcReset;
    assign o_pc_stall    = w_pcStall;
    assign o_pc_next     = w_pcNext;
    assign o_if_id_stall = w_ifIdStall;
    assign o_if_id_flush = w_ifIdFlush;
    assign o_id_ex_flush = w_idExFlush;
    assign o_pipe_freeze = w_pipeFreeze;

`ifdef STALL_CNT_EN
    logic [31:0] r_stallCycles;
    logic [31:0] r_flushCount;
    logic        w_countStall;

    assign w_countStall = ((r_state == ST_RUN) || (r_state == ST_DROP)) && w_pcStall;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stallCycles <= '0;
            r_flushCount  <= '0;
        end else begin
            if (w_countStall && (r_stallCycles != 32'hFFFF_FFFF)) begin
                r_stallCycles <= r_stallCycles + 32'd1;
            end
            if (w_redirectTaken && (r_flushCount != 32'hFFFF_FFFF)) begin
                r_flushCount <= r_flushCount + 32'd1;
            end
        end
    end

    assign o_stall_cycles = r_stallCycles;
    assign o_flush_count  = r_flushCount;
`else
    logic w_unusedRedirect;

    assign w_unusedRedirect = w_redirectTaken;
    assign o_stall_cycles   = 32'd0;
    assign o_flush_count    = 32'd0;
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-stage controller that sequences the program counter register of the pipelined RV32 core. Each cycle it computes the PC's next value and its stall/reset controls, and drives the IF/ID and ID/EX stall and flush strobes. It arbitrates between data-memory back-pressure, EX-stage branch/jump redirects, load-use hazards and instruction-memory wait states. It also discards a stale instruction fetch that is still outstanding when a redirect occurs.

## Interface
- RESET_HOLD_CYCLES, 4: cycles `pc_reset` stays high after RST deasserts; legal values ≥1
- RESET_VECTOR, 32'h0000_0000: value driven on `pc_next` while in HOLD
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- pc_cur  in  32  current PC register value
- imem_ready  in  1  instruction-memory fetch response valid this cycle
- dmem_busy  in  1  MEM-stage data memory not ready; freezes pipeline
- id_rs1, id_rs2  in  5 each  ID-stage source registers
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source
- ex_rd  in  5  EX-stage destination register
- ex_mem_read  in  1  EX instruction is a load
- ex_redirect  in  1  taken branch or jump resolved in EX
- ex_target  in  32  redirect target address
- pc_reset  out  1  drives PC reset
- pc_stall  out  1  drives PC stall enable
- pc_next  out  32  drives PC input
- if_id_stall  out  1  hold IF/ID register
- if_id_flush  out  1  load bubble into IF/ID
- id_ex_flush  out  1  load bubble into ID/EX
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- stall_cycles  out  32  stall counter (see Configuration)
- flush_count  out  32  redirect counter (see Configuration)

## Operation
- FSM states: HOLD, RUN, DROP. RST forces HOLD with the hold counter loaded to RESET_HOLD_CYCLES.
- HOLD:
  - `pc_reset`=1, `pc_next`=RESET_VECTOR; all other strobes 0.
  - The counter decrements each edge; at 0 the FSM enters RUN.
- RUN, strict priority, first match wins:
  1. `dmem_busy`: `pipe_freeze`=1, `pc_stall`=1, `if_id_stall`=1, no flushes; `ex_redirect` is ignored because EX is held.
  2. `ex_redirect`: `pc_next`={ex_target[31:2],2'b00}, `pc_stall`=0, `if_id_flush`=1, `id_ex_flush`=1. If `imem_ready`=0, next state is DROP.
  3. Load-use, defined as `ex_mem_read` && `ex_rd`≠0 && ((`id_uses_rs1` && `id_rs1`==`ex_rd`) || (`id_uses_rs2` && `id_rs2`==`ex_rd`)): `pc_stall`=1, `if_id_stall`=1, `id_ex_flush`=1.
  4. `imem_ready`=0: `pc_stall`=1, `if_id_flush`=1.
  5. Otherwise: `pc_next`=`pc_cur`+4, truncated to 32 bits (0xFFFF_FFFC wraps to 0); all strobes 0.
- DROP:
  - `pc_stall`=1, `if_id_flush`=1.
  - `dmem_busy` additionally asserts `pipe_freeze` and `if_id_stall`.
  - The first cycle with `imem_ready`=1 consumes the stale response, which is flushed; next state is RUN.
  - `ex_redirect` cannot occur in DROP because EX was flushed. If it is asserted anyway, it is ignored.
- `pc_next` = `pc_cur` in every state and case not listed above.

## Timing
- All outputs are combinational from state and inputs; state, counters and the hold counter are registered.
- Reset values: `pc_reset`=1, `pc_next`=RESET_VECTOR, all other outputs 0.
- RST deasserted before edge 0: `pc_reset` is high for exactly RESET_HOLD_CYCLES edges. The first RUN cycle sees `pc_cur`=RESET_VECTOR.
- Redirect latency: the PC holds the target one edge after `ex_redirect`. The target instruction is valid in IF/ID one edge after `imem_ready` for the target.
- Load-use stall lasts exactly 1 cycle.
- RST asserted mid-operation: outputs return to reset values immediately, without waiting for CLK, and DROP is abandoned.

## Configuration
- `STALL_CNT_EN` defined:
  - `stall_cycles` increments on each edge where `pc_stall`=1 in RUN or DROP.
  - `flush_count` increments on each accepted redirect.
  - Both saturate at 0xFFFF_FFFF and clear on RST.
- Undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- Reset, RESET_HOLD_CYCLES=4: RST pulse then release → `pc_reset`=1 for 4 edges, then `pc_next`=0x4 with `pc_cur`=0.
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_uses_rs2`=1 → one cycle of `pc_stall`=`if_id_stall`=`id_ex_flush`=1. `ex_rd`=0 gives no stall.
- Redirect with fetch pending: `ex_redirect`=1, `ex_target`=0x103, `imem_ready`=0 → `pc_next`=0x100, both flushes=1, enter DROP. Hold `imem_ready`=0 for 3 cycles, then 1 → `if_id_flush` high through the ready cycle, then RUN.
- dmem_busy with `ex_redirect` both asserted → `pipe_freeze`=1, PC held, no flush. Drop `dmem_busy` → redirect is taken that cycle.
- Wrap: `pc_cur`=0xFFFF_FFFC, all clear → `pc_next`=0x0.
- `STALL_CNT_EN`: 3 imem-wait cycles plus 2 redirects → `stall_cycles`=3, `flush_count`=2. Without the macro both read 0.
